memory_access: RTL and testbench
================================

// Module: memory_access
// PURPOSE
//  MEM pipeline stage, directly downstream of the execution stage.
//  Consumes the registered ALU result, B operand, MEM and WB control, and PC from EX.
//  Performs byte/half/word loads and stores on an internal single-port data RAM.
//  Delivers registered load data, ALU result, WB control and PC to the write-back stage.
// PARAMETERS
//  NB_REG   32  datapath / register width
//  NB_MEM   5   MEM control field width
//  NB_WB    8   WB control field width (passed through untouched)
//  NB_ADDR  10  data RAM word-address bits (2**NB_ADDR words of NB_REG bits)
// PORTS
//  i_clock       in   1         clock; all logic is on the rising edge
//  i_reset       in   1         synchronous, active-high reset
//  i_valid       in   1         stage enable; low = stall (outputs hold, no store)
//  i_alu         in   NB_REG    byte address for loads/stores, or ALU result to pass through
//  i_b           in   NB_REG    store data (rt)
//  i_mem         in   NB_MEM    {wr, rd, size[1:0], unsigned}; size 00=B, 01=H, 11=W
//  i_wb          in   NB_WB     WB control
//  i_pc          in   NB_REG    PC of the instruction
//  i_dbg_addr    in   NB_ADDR   debug-unit word address
//  o_data        out  NB_REG    aligned and extended load data
//  o_alu         out  NB_REG    registered i_alu
//  o_wb          out  NB_WB     registered i_wb
//  o_pc          out  NB_REG    registered i_pc
//  o_misaligned  out  1         access in this output slot was misaligned
//  o_dbg_data    out  NB_REG    RAM word at i_dbg_addr, registered
// BEHAVIOUR
//  - Reset: o_data, o_alu, o_wb, o_pc, o_misaligned and o_dbg_data go to 0 on the edge where i_reset=1.
//    RAM contents are not cleared. Reset has priority over i_valid and suppresses any store that cycle.
//  - Latency: 1 cycle. On an edge with i_valid=1, all outputs update together from that cycle's inputs.
//    On an edge with i_valid=0, all outputs except o_dbg_data hold.
//  - Word index = i_alu[NB_ADDR+1:2]; upper address bits are ignored (address wraps modulo RAM size).
//  - Lane = i_alu[1:0], little-endian: byte k occupies bits [8k+7:8k].
//  - Alignment: H needs i_alu[0]=0; W needs i_alu[1:0]=00; B is always aligned.
//  - Store (wr=1, i_valid=1, aligned):
//    - B writes lane i_b[7:0]
//    - H writes lanes {a1,0},{a1,1} with i_b[15:0]
//    - W writes the whole word
//    - Other bytes of the word are unchanged.
//  - Load (rd=1): select the lane(s); zero-extend if unsigned=1, else sign-extend. W is returned as-is.
//  - Neither rd nor wr: o_data=0. rd and wr both set: treated as store; o_data=0.
//  - Misaligned access:
//    - o_misaligned=1 and o_data=0
//    - a misaligned store is suppressed (RAM unchanged)
//    - o_alu, o_wb and o_pc still pass through.
//  - Read-during-write to the same word in one cycle: read-first (old data).
//  - Debug port: o_dbg_data <= RAM[i_dbg_addr] every edge regardless of i_valid, read-first.
//  - Implementation: RAM inferable as block RAM (synchronous read); lane select and extension are registered.
// TESTING
//  1. Reset at timer 2 with garbage inputs -> all outputs 0 on the next edge; a store issued that cycle does not land.
//  2. SW 0xDEADBEEF @0x10, then LW @0x10 -> o_data=0xDEADBEEF; o_alu=0x10, o_wb and o_pc echo the LW's inputs.
//  3. LB @0x13 (signed) -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
//  4. SB 0x55 @0x11, then LW @0x10 -> 0xDEAD55EF. SH 0x1234 @0x12, then LW -> 0x123455EF.
//  5. SW 0xAAAAAAAA @0x12 (misaligned) -> o_misaligned=1, o_data=0; LW @0x10 still returns 0x123455EF.
//  6. Hold i_valid=0 for 3 cycles with a store request -> outputs hold and RAM is unchanged.
//     Then LW @0x10+(4<<NB_ADDR) -> aliases to 0x10.

Source files
------------

// File: rtl/memory_access.sv
// memory_access: MEM pipeline stage with byte/half/word loads and stores on an internal data RAM
module memory_access #(
  parameter int NB_REG  = 32,
  parameter int NB_MEM  = 5,
  parameter int NB_WB   = 8,
  parameter int NB_ADDR = 10
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [NB_REG-1:0]  i_alu,
  input  logic [NB_REG-1:0]  i_b,
  input  logic [NB_MEM-1:0]  i_mem,
  input  logic [NB_WB-1:0]   i_wb,
  input  logic [NB_REG-1:0]  i_pc,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  output logic [NB_REG-1:0]  o_data,
  output logic [NB_REG-1:0]  o_alu,
  output logic [NB_WB-1:0]   o_wb,
  output logic [NB_REG-1:0]  o_pc,
  output logic               o_misaligned,
  output logic [NB_REG-1:0]  o_dbg_data
);
  logic [NB_REG-1:0] ram [0:(1<<NB_ADDR)-1];
  logic wr, rd, uns, is_h, is_w, mis, we;
  logic [1:0] size, lane;
  logic [NB_ADDR-1:0] idx;
  logic [3:0] be;
  logic [NB_REG-1:0] wdata, rd_word, sh;
  logic ld_q, uns_q;
  logic [1:0] size_q, lane_q;
  logic unused_bits;
  assign unused_bits = ^{i_alu[NB_REG-1:NB_ADDR+2], sh[NB_REG-1:16]};
  // decode control, alignment, byte enables and replicated store data
  always_comb begin
    wr    = i_mem[4];
    rd    = i_mem[3];
    size  = i_mem[2:1];
    uns   = i_mem[0];
    lane  = i_alu[1:0];
    idx   = i_alu[NB_ADDR+1:2];
    is_w  = size[1];
    is_h  = size == 2'b01;
    mis   = (wr | rd) & ((is_h & lane[0]) | (is_w & (lane != 2'b00)));
    we    = i_valid & ~i_reset & wr & ~mis;
    be    = is_w ? 4'hf : is_h ? (lane[1] ? 4'hc : 4'h3) : 4'b0001 << lane;
    wdata = is_w ? i_b : is_h ? {2{i_b[15:0]}} : {4{i_b[7:0]}};
  end
  // byte-enabled RAM with read-first synchronous read, enabled with the stage
  always_ff @(posedge i_clock) begin
    for (int k = 0; k < 4; k++)
      if (we && be[k]) ram[idx][8*k +: 8] <= wdata[8*k +: 8];
    if (i_valid) rd_word <= ram[idx];
  end
  // pipeline registers, debug read and the load-format fields for the next slot
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_alu        <= '0;
      o_wb         <= '0;
      o_pc         <= '0;
      o_misaligned <= 1'b0;
      o_dbg_data   <= '0;
      ld_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= '0;
      lane_q       <= '0;
    end else begin
      o_dbg_data <= ram[i_dbg_addr];
      if (i_valid) begin
        o_alu        <= i_alu;
        o_wb         <= i_wb;
        o_pc         <= i_pc;
        o_misaligned <= mis;
        ld_q         <= rd & ~wr & ~mis;
        uns_q        <= uns;
        size_q       <= size;
        lane_q       <= lane;
      end
    end
  end
  // lane select and extension from the registered word and registered format
  always_comb begin
    sh     = rd_word >> {lane_q, 3'b000};
    o_data = !ld_q     ? '0 :
             size_q[1] ? rd_word :
             size_q[0] ? {{16{~uns_q & sh[15]}}, sh[15:0]} :
                         {{24{~uns_q & sh[7]}}, sh[7:0]};
  end
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: scoreboard bench for the MEM stage
module tb_memory_access;
  logic        clk = 1'b0;
  logic        rst, valid;
  logic [31:0] alu, b, pc;
  logic [4:0]  mem;
  logic [7:0]  wb;
  logic [9:0]  dbg_addr;
  logic [31:0] o_data, o_alu, o_pc, o_dbg;
  logic [7:0]  o_wb;
  logic        o_mis;
  int n_cmp = 0, n_err = 0;

  typedef struct packed {
    logic [31:0] data, alu, pc, dbg;
    logic [7:0]  wb;
    logic        mis, dchk;
  } exp_t;

  exp_t sb[$];
  exp_t last;

  localparam logic [4:0] SW = 5'b10110, SH = 5'b10010, SB = 5'b10000, LW = 5'b01110,
                         LH = 5'b01010, LHU = 5'b01011, LB = 5'b01000, LBU = 5'b01001;

  memory_access dut (
    .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_alu(alu), .i_b(b), .i_mem(mem),
    .i_wb(wb), .i_pc(pc), .i_dbg_addr(dbg_addr), .o_data(o_data), .o_alu(o_alu),
    .o_wb(o_wb), .o_pc(o_pc), .o_misaligned(o_mis), .o_dbg_data(o_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] d, a, input logic [7:0] w, input logic [31:0] p,
                              input logic m, input logic [31:0] dbg, input logic dc);
    mk = '{data: d, alu: a, pc: p, dbg: dbg, wb: w, mis: m, dchk: dc};
  endfunction

  task automatic step(input string tag, input logic r, v, input logic [31:0] a, bb,
                      input logic [4:0] m, input logic [7:0] w, input logic [31:0] p, input exp_t e);
    exp_t g;
    @(negedge clk);
    rst = r; valid = v; alu = a; b = bb; mem = m; wb = w; pc = p;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check({tag, ".data"}, o_data, g.data);
    check({tag, ".alu"}, o_alu, g.alu);
    check({tag, ".wb"}, {24'd0, o_wb}, {24'd0, g.wb});
    check({tag, ".pc"}, o_pc, g.pc);
    check({tag, ".mis"}, {31'd0, o_mis}, {31'd0, g.mis});
    if (g.dchk) check({tag, ".dbg"}, o_dbg, g.dbg);
    last = g;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; valid = 1'b0; alu = '0; b = '0; mem = '0; wb = '0; pc = '0; dbg_addr = 10'd4;
    step("rst0", 1, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1));
    step("sw20", 0, 1, 32'h20, 32'h11111111, SW, 8'h01, 32'h100, mk(0, 32'h20, 8'h01, 32'h100, 0, 0, 0));
    step("rst_garbage", 1, 1, 32'h20, 32'h22222222, SW, 8'hff, 32'hffffffff, mk(0, 0, 0, 0, 0, 0, 1));
    step("lw20", 0, 1, 32'h20, 32'h0, LW, 8'h02, 32'h104, mk(32'h11111111, 32'h20, 8'h02, 32'h104, 0, 0, 0));
    step("sw10", 0, 1, 32'h10, 32'hDEADBEEF, SW, 8'h03, 32'h108, mk(0, 32'h10, 8'h03, 32'h108, 0, 0, 0));
    step("lw10", 0, 1, 32'h10, 32'h0, LW, 8'h04, 32'h10c, mk(32'hDEADBEEF, 32'h10, 8'h04, 32'h10c, 0, 32'hDEADBEEF, 1));
    step("lb13", 0, 1, 32'h13, 32'h0, LB, 8'h05, 32'h110, mk(32'hFFFFFFDE, 32'h13, 8'h05, 32'h110, 0, 32'hDEADBEEF, 1));
    step("lbu13", 0, 1, 32'h13, 32'h0, LBU, 8'h06, 32'h114, mk(32'h000000DE, 32'h13, 8'h06, 32'h114, 0, 32'hDEADBEEF, 1));
    step("lh12", 0, 1, 32'h12, 32'h0, LH, 8'h07, 32'h118, mk(32'hFFFFDEAD, 32'h12, 8'h07, 32'h118, 0, 32'hDEADBEEF, 1));
    step("lhu10", 0, 1, 32'h10, 32'h0, LHU, 8'h08, 32'h11c, mk(32'h0000BEEF, 32'h10, 8'h08, 32'h11c, 0, 32'hDEADBEEF, 1));
    step("lh10", 0, 1, 32'h10, 32'h0, LH, 8'h09, 32'h120, mk(32'hFFFFBEEF, 32'h10, 8'h09, 32'h120, 0, 32'hDEADBEEF, 1));
    step("sb11", 0, 1, 32'h11, 32'h12345655, SB, 8'h0a, 32'h124, mk(0, 32'h11, 8'h0a, 32'h124, 0, 32'hDEADBEEF, 1));
    step("lw10b", 0, 1, 32'h10, 32'h0, LW, 8'h0b, 32'h128, mk(32'hDEAD55EF, 32'h10, 8'h0b, 32'h128, 0, 32'hDEAD55EF, 1));
    step("lb11", 0, 1, 32'h11, 32'h0, LB, 8'h0c, 32'h12c, mk(32'h00000055, 32'h11, 8'h0c, 32'h12c, 0, 32'hDEAD55EF, 1));
    step("sh12", 0, 1, 32'h12, 32'hABCD1234, SH, 8'h0d, 32'h130, mk(0, 32'h12, 8'h0d, 32'h130, 0, 32'hDEAD55EF, 1));
    step("lw10c", 0, 1, 32'h10, 32'h0, LW, 8'h0e, 32'h134, mk(32'h123455EF, 32'h10, 8'h0e, 32'h134, 0, 32'h123455EF, 1));
    step("none", 0, 1, 32'h10, 32'h0, 5'b00110, 8'h0f, 32'h138, mk(0, 32'h10, 8'h0f, 32'h138, 0, 32'h123455EF, 1));
    step("sw_mis", 0, 1, 32'h12, 32'hAAAAAAAA, SW, 8'h10, 32'h13c, mk(0, 32'h12, 8'h10, 32'h13c, 1, 32'h123455EF, 1));
    step("lh_mis", 0, 1, 32'h11, 32'h0, LH, 8'h11, 32'h140, mk(0, 32'h11, 8'h11, 32'h140, 1, 32'h123455EF, 1));
    step("lw10d", 0, 1, 32'h10, 32'h0, LW, 8'h12, 32'h144, mk(32'h123455EF, 32'h10, 8'h12, 32'h144, 0, 32'h123455EF, 1));
    for (int i = 0; i < 3; i++) begin
      exp_t h;
      h = last;
      step("stall", 0, 0, 32'h10, 32'hFFFFFFFF, SW, 8'h80, 32'h200, h);
    end
    step("lw_alias", 0, 1, 32'h10 + (32'd4 << 10), 32'h0, LW, 8'h13, 32'h148,
         mk(32'h123455EF, 32'h1010, 8'h13, 32'h148, 0, 32'h123455EF, 1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
